// File: rtl/sales_pkg.sv
// rtl/sales_pkg.sv - shared order types and widths for the sales datapath
package sales_pkg;

    localparam int PRICE_W = 32;
    localparam int NUM_W   = 32;

    typedef struct packed {
        logic [PRICE_W-1:0] price;
        logic [NUM_W-1:0]   num;
    } order_t;

    localparam order_t IDLE_ORDER = '0;

endpackage

// File: rtl/order_fifo.sv
// rtl/order_fifo.sv - synchronous FIFO of order_t with separately tracked occupancy
module order_fifo
    import sales_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  order_t                   wdata,
    output order_t                   rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    order_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Guards keep pointers and level consistent even if a caller misbehaves.
    assign push_ok = push && (level != FULL);
    assign pop_ok  = pop && (level != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/order_feeder.sv
// rtl/order_feeder.sv - buffers orders and feeds one price/num beat per clock to sales
module order_feeder
    import sales_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRICE_W-1:0]       in_price,
    input  logic [NUM_W-1:0]         in_num,
    input  logic                     pause,
    output logic [PRICE_W-1:0]       price,
    output logic [NUM_W-1:0]         num,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              drop_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic   accept;
    logic   push;
    logic   pop;
    order_t wdata;
    order_t rdata;

    assign in_ready = (level != FULL);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_num != '0);
    // Pop looks only at pre-edge occupancy, so a fresh order never bypasses the FIFO.
    assign pop      = (level != '0) && !pause;
    assign wdata    = '{price: in_price, num: in_num};

    order_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            price    <= '0;
            num      <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                price <= rdata.price;
                num   <= rdata.num;
            end else begin
                price <= IDLE_ORDER.price;
                num   <= IDLE_ORDER.num;
            end
            if (accept && (in_num == '0)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_order_feeder.sv
// tb/tb_order_feeder.sv - scoreboard bench for order_feeder against a queue-based order model
module tb_order_feeder;
    import sales_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_price;
    logic [31:0]    in_num;
    logic           pause;
    logic [31:0]    price;
    logic [31:0]    num;
    logic [LW-1:0]  level;
    logic [31:0]    drop_cnt;

    int     checks = 0;
    int     errors = 0;
    order_t mq[$];
    order_t exp_q[$];
    int     m_drop = 0;
    bit     started = 1'b0;
    bit     toggle = 1'b0;

    order_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_price (in_price),
        .in_num   (in_num),
        .pause    (pause),
        .price    (price),
        .num      (num),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a list of pending orders; each edge emits the oldest one unless paused or empty.
    always @(posedge clk) begin
        order_t beat;
        bit     acc;
        beat = IDLE_ORDER;
        if (rst) begin
            mq.delete();
            m_drop = 0;
        end else begin
            acc = in_valid && (mq.size() != DEPTH);
            if (mq.size() != 0 && !pause) beat = mq.pop_front();
            if (acc) begin
                if (in_num == 0) m_drop = m_drop + 1;
                else mq.push_back('{price: in_price, num: in_num});
            end
        end
        exp_q.push_back(beat);
        started = 1'b1;
    end

    always @(negedge clk) begin
        order_t e;
        if (started) begin
            if (exp_q.size() == 0) begin
                chk("beat_available", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {price, num}, e);
            end
            chk("level", 64'(level), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) pause = ~pause;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] n);
        bit acc;
        int cnt;
        in_valid = 1'b1;
        in_price = p;
        in_num   = n;
        cnt      = 0;
        do begin
            acc = in_ready;
            tick();
            cnt++;
        end while (!acc && cnt < 50);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_price = '0; in_num = '0; pause = 1'b0;
        tick();
        rst = 1'b0;

        idle(2);
        send(1, 2);
        idle(3);

        send(1, 2); send(2, 1); send(3, 3);
        idle(4);

        pause = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i * 10), 32'(i));
        in_valid = 1'b1; in_price = 50; in_num = 5;
        tick(); tick();
        pause = 1'b0;
        send(50, 5);
        idle(6);

        send(7, 0); send(8, 4); send(9, 0);
        idle(3);
        chk("drop_after_filter", 64'(drop_cnt), 64'd2);

        pause = 1'b1;
        send(11, 1); send(12, 2); send(13, 3);
        rst = 1'b1; in_valid = 1'b1; in_price = 14; in_num = 4;
        tick();
        rst = 1'b0; in_valid = 1'b0; pause = 1'b0;
        idle(5);

        pause = 1'b1;
        send(20, 1); send(21, 2);
        toggle = 1'b1;
        for (int i = 0; i < 4; i++) send(32'(30 + i), 32'(i + 1));
        toggle = 1'b0; pause = 1'b0;
        idle(8);

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            in_valid = $urandom_range(0, 1);
            in_price = $urandom;
            in_num   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            pause    = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0; pause = 1'b0;
        idle(DEPTH + 3);
        chk("drained", 64'(level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/order_feeder.md
# order_feeder

Upstream stage of the `sales` running-average block: accepts purchase orders (unit price, quantity) over a valid/ready handshake, buffers them in a small FIFO, and presents at most one order per clock on the `price`/`num` bus that `sales` samples every rising edge. When no order is available, it drives an idle beat (`price = 0`, `num = 0`). Zero-quantity orders are absorbed and counted, never forwarded. A `pause` input lets the integrator freeze delivery without losing orders.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, ≥ 2.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: an order is offered on `in_price`/`in_num`.
- `in_ready`, output, 1: the block can take an order this cycle.
- `in_price`, input, 32: unsigned unit price of the offered order.
- `in_num`, input, 32: unsigned quantity of the offered order.
- `pause`, input, 1: when 1, no order is popped this cycle.
- `price`, output, 32: registered unit price to `sales`.
- `num`, output, 32: registered quantity to `sales`; 0 means idle beat.
- `level`, output, $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `drop_cnt`, output, 32: number of zero-quantity orders absorbed since reset.

## Operation
- Accept: an order is accepted when `in_valid && in_ready`.
- `in_ready = (level != DEPTH)`. It is combinational from registered state only; it never depends on `in_valid` or `pause`.
- An accepted order with `in_num == 0`:
  - is not written to the FIFO;
  - increments `drop_cnt`, which wraps modulo 2^32;
  - does not change `level`.
- An accepted order with `in_num != 0` is written at the tail.
- Pop: when `level != 0 && !pause`, the head entry is loaded into `price`/`num` and removed.
- Otherwise `price` and `num` are loaded with 0. A paused or empty cycle therefore always yields an idle beat; the previous order is never repeated.
- Push and pop in the same cycle are both performed; `level` is unchanged.
- Full and pop together: `in_ready` is already 0, so no push happens.
- Empty and push together: the new order is not visible to the pop logic in the same cycle. Pop uses pre-edge `level`; there is no bypass.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked separately, so full and empty are unambiguous.
- Values are passed through unmodified. No arithmetic is done on `price`/`num`.

## Timing
- Reset (`rst` = 1 at an edge):
  - `price`, `num`, `level`, `drop_cnt` and both pointers go to 0;
  - after that edge, `in_ready` = 1.
- During reset:
  - any handshake on `in_valid` in that cycle is ignored;
  - FIFO contents are discarded.
- Reset mid-stream flushes all buffered orders. The first post-reset beat is idle.
- Latency: an order accepted at edge N into an empty FIFO appears on `price`/`num` after edge N+1. `sales` consumes it at edge N+2.
- Throughput: one order per cycle sustained, with no bubbles while `level` > 0 and `pause` = 0.
- `pause` is sampled at the same edge as the pop decision. Deasserting it resumes delivery on the next edge.

## Structure
- Shared package `sales_pkg`:
  - `PRICE_W = 32`, `NUM_W = 32`;
  - `order_t` packed struct {price, num};
  - `IDLE_ORDER` constant (all zero).
- Sub-module `order_fifo`:
  - synchronous FIFO of `order_t`, parameter `DEPTH`;
  - ports `push`, `pop`, `wdata`, `rdata`, `level`;
  - holds storage and pointers.
- Top level `order_feeder` holds:
  - the handshake;
  - the zero-quantity filter;
  - the drop counter;
  - the output register.

## Test plan
- Reset then single order: assert `rst` for one edge, then offer (price 1, num 2) for one cycle.
  - Required: `in_ready` = 1, and `price`/`num` = 1/2 for exactly one cycle after the next edge.
  - Required: idle (0/0) before and after.
- Back-to-back stream: offer (1,2), (2,1), (3,3) on consecutive cycles with `pause` = 0.
  - Required: outputs are 1/2, 2/1, 3/3 on three consecutive beats.
  - Required: `level` never exceeds 1.
- Fill and backpressure: `pause` = 1, offer 5 orders with `DEPTH` = 4 and `in_valid` held high.
  - Required: 4 orders accepted, `in_ready` = 0 with `level` = 4, 5th order held.
  - Then release `pause`. Required: the 4 orders are output in order, the 5th is accepted on the cycle after the first pop and is output 5th.
- Zero-quantity filter: offer (7,0), (8,4), (9,0).
  - Required: `drop_cnt` = 2.
  - Required: the only non-idle beat is 8/4.
  - Required: `level` peaks at 1.
- Reset mid-stream: with `level` = 3, assert `rst` for one edge while `in_valid` = 1.
  - Required: `level` = 0, `drop_cnt` = 0, outputs 0/0.
  - Required: no buffered or offered order ever appears afterwards.
- Pause with simultaneous push and pop: at `level` = 2, toggle `pause` every cycle while offering one order per cycle.
  - Required: idle beats exactly on the paused cycles.
  - Required: `level` rises by 1 on paused cycles and stays constant on unpaused ones.
  - Required: output order matches acceptance order.
